// File: rtl/debounce_pkg.sv
// Shared constants for the board-input debouncer: 100 MHz timing defaults and channel map.
// Latency: n/a (constants only). Backpressure: n/a.
// Optional auto-repeat is enabled with DEBOUNCE_AUTOREPEAT_EN.
package debounce_pkg;

    localparam int DB_CYCLES_DEFAULT   = 1_000_000;   // 10 ms @ 100 MHz
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int RPT_DELAY_DEFAULT   = 50_000_000;  // 500 ms
    localparam int RPT_RATE_DEFAULT    = 20_000_000;  // 200 ms

    localparam int SW0        = 0;
    localparam int SW1        = 1;
    localparam int SW2        = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 4;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 6;
    localparam int BTN_CENTER = 7;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, level, rise/fall strobes, optional repeat.
// Latency: SYNC_STAGES + DB_CYCLES cycles from a stable in_raw step to level change.
// Backpressure: none; strobes are single-cycle and unconditional. Repeat under DEBOUNCE_AUTOREPEAT_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int RPT_DELAY   = RPT_DELAY_DEFAULT,
    parameter int RPT_RATE    = RPT_RATE_DEFAULT
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   take;

    assign s    = sync[SYNC_STAGES-1];
    // Counter saturates at CNT_MAX: that edge commits the new level instead of wrapping.
    assign take = (s != level) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in_raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (take) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(max_int(RPT_DELAY, RPT_RATE));
    localparam logic [RPT_W-1:0] DLY_MAX  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_MAX = RPT_W'(RPT_RATE - 1);

    logic [RPT_W-1:0] rcnt;
    logic             first;

    // 'first' selects the initial hold delay; afterwards the shorter repeat period applies.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt  <= '0;
            first <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (take && s) begin
                rcnt  <= '0;
                first <= 1'b1;
            end else if (take || !level) begin
                rcnt  <= '0;
                first <= 1'b0;
            end else if (rcnt == (first ? DLY_MAX : RATE_MAX)) begin
                rpt   <= 1'b1;
                rcnt  <= '0;
                first <= 1'b0;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent board-input debouncers (switches/buttons) feeding the control FSMs.
// Latency: SYNC_STAGES + DB_CYCLES cycles per channel. Backpressure: none.
// Hold-to-repeat strobes exist only when DEBOUNCE_AUTOREPEAT_EN is defined; otherwise db_rpt is 0.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int RPT_DELAY   = RPT_DELAY_DEFAULT,
    parameter int RPT_RATE    = RPT_RATE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic [N_CH-1:0] db_rpt
);

    if (N_CH < 1 || DB_CYCLES < 2 || SYNC_STAGES < 2 || RPT_DELAY < 2 || RPT_RATE < 2) begin : g_bad_params
        $error("debounce_bank: parameter out of range");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_AUTOREPEAT_EN
            ,
            .RPT_DELAY   (RPT_DELAY),
            .RPT_RATE    (RPT_RATE)
`endif
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .in_raw (in_raw[i]),
            .level  (db_level[i]),
            .rise   (db_rise[i]),
            .fall   (db_fall[i]),
            .rpt    (db_rpt[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (N_CH=8, DB_CYCLES=16, SYNC_STAGES=2, RPT_DELAY=40, RPT_RATE=10).
// Repeat checks follow DEBOUNCE_AUTOREPEAT_EN when it is defined.
module tb_debounce_bank;

    logic       clk;
    logic       reset;
    logic [7:0] in_raw;
    logic [7:0] db_level;
    logic [7:0] db_rise;
    logic [7:0] db_fall;
    logic [7:0] db_rpt;

    int checks;
    int failures;
    logic [7:0] acc_rise;
    logic [7:0] acc_fall;

    debounce_bank #(
        .N_CH        (8),
        .DB_CYCLES   (16),
        .SYNC_STAGES (2),
        .RPT_DELAY   (40),
        .RPT_RATE    (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_raw   (in_raw),
        .db_level (db_level),
        .db_rise  (db_rise),
        .db_fall  (db_fall),
        .db_rpt   (db_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and accumulating strobes.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            acc_rise = acc_rise | db_rise;
            acc_fall = acc_fall | db_fall;
        end
    endtask

    task automatic clr_acc();
        acc_rise = '0;
        acc_fall = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr_acc();
        reset  = 1'b1;
        in_raw = 8'hFF;

        // Reset with all inputs high: everything stays 0.
        tick(3);
        check("reset_outputs", {db_level, db_rise, db_fall, db_rpt}, 32'h0);
        reset = 1'b0;
        clr_acc();
        tick(17);
        check("release_level_early", {24'h0, db_level}, 32'h00);
        check("release_no_rise_early", {24'h0, acc_rise}, 32'h00);
        tick(1);
        check("release_level_18", {24'h0, db_level}, 32'hFF);
        check("release_rise_18", {24'h0, db_rise}, 32'hFF);
        tick(1);
        check("release_rise_clears", {24'h0, db_rise}, 32'h00);

        // All inputs low: one fall strobe on every channel.
        in_raw = 8'h00;
        clr_acc();
        tick(17);
        check("all_fall_early", {24'h0, acc_fall}, 32'h00);
        tick(1);
        check("all_fall_18", {24'h0, db_fall}, 32'hFF);
        check("all_level_low", {24'h0, db_level}, 32'h00);
        tick(1);
        check("all_fall_clears", {24'h0, db_fall}, 32'h00);

        // ch0 clean step.
        in_raw = 8'h01;
        clr_acc();
        tick(17);
        check("ch0_no_rise_17", {24'h0, acc_rise}, 32'h00);
        tick(1);
        check("ch0_rise_18", {24'h0, db_rise}, 32'h01);
        check("ch0_level_18", {24'h0, db_level}, 32'h01);
        tick(1);
        check("ch0_rise_single", {24'h0, db_rise}, 32'h00);
        check("ch0_level_hold", {24'h0, db_level}, 32'h01);

        // ch1 bounce: high 10, low 3, then high; only the final edge counts.
        clr_acc();
        in_raw = 8'h03;
        tick(10);
        in_raw = 8'h01;
        tick(3);
        in_raw = 8'h03;
        tick(17);
        check("ch1_bounce_no_rise", {24'h0, acc_rise}, 32'h00);
        check("ch1_bounce_level", {24'h0, db_level}, 32'h01);
        tick(1);
        check("ch1_rise_18", {24'h0, db_rise}, 32'h02);
        check("ch1_level", {24'h0, db_level}, 32'h03);
        tick(2);

        // ch2: settle high, then two 15-cycle low pulses, then a long low.
        in_raw = 8'h07;
        tick(18);
        check("ch2_rise", {24'h0, db_rise}, 32'h04);
        tick(2);
        clr_acc();
        for (int p = 0; p < 2; p++) begin
            in_raw = 8'h03;
            tick(15);
            in_raw = 8'h07;
            tick(5);
        end
        check("ch2_short_no_fall", {24'h0, acc_fall}, 32'h00);
        check("ch2_short_level", {24'h0, db_level}, 32'h07);
        in_raw = 8'h03;
        clr_acc();
        tick(17);
        check("ch2_long_no_fall_17", {24'h0, acc_fall}, 32'h00);
        tick(1);
        check("ch2_fall_18", {24'h0, db_fall}, 32'h04);
        check("ch2_level_low", {24'h0, db_level}, 32'h03);
        tick(1);
        check("ch2_fall_single", {24'h0, db_fall}, 32'h00);

        // ch4 reset mid-count (cnt=10); input stays high through reset.
        in_raw = 8'h13;
        clr_acc();
        tick(12);
        reset = 1'b1;
        tick(2);
        check("midreset_outputs", {db_level, db_rise, db_fall, db_rpt}, 32'h0);
        reset = 1'b0;
        tick(17);
        check("midreset_no_rise", {24'h0, acc_rise}, 32'h00);
        tick(1);
        check("midreset_rise_18", {24'h0, db_rise}, 32'h13);
        check("midreset_level", {24'h0, db_level}, 32'h13);
        tick(1);

        // ch3 hold: repeat strobes at +40, +50, ... +100 after the rise.
        in_raw = 8'h1B;
        tick(18);
        check("ch3_rise", {24'h0, db_rise}, 32'h08);
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            check("rise_fall_exclusive", {24'h0, db_rise & db_fall}, 32'h00);
`ifdef DEBOUNCE_AUTOREPEAT_EN
            check($sformatf("ch3_rpt_%0d", k), {31'h0, db_rpt[3]},
                  {31'h0, (k >= 40) && ((k - 40) % 10 == 0)});
`else
            check($sformatf("rpt_zero_%0d", k), {24'h0, db_rpt}, 32'h00);
`endif
        end

        // Release ch3: fall after full interval, no repeat strobe then.
        in_raw = 8'h13;
        clr_acc();
        tick(17);
        check("ch3_no_fall_17", {24'h0, acc_fall}, 32'h00);
        tick(1);
        check("ch3_fall_18", {24'h0, db_fall}, 32'h08);
        check("ch3_rpt_on_fall", {31'h0, db_rpt[3]}, 32'h0);
        tick(12);
        check("ch3_rpt_after_release", {31'h0, db_rpt[3]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
